// File: rtl/logic_op_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_arb_pkg
// Brief    : State encoding, op-select codes and defaults for logic_op_arb.
// Revision : 1.0 - initial release
// ============================================================================
package logic_op_arb_pkg;

    localparam int c_timeout_default = 15;
    localparam int c_data_w          = 4;
    localparam int c_sel_w           = 2;
    localparam int c_st_w            = 2;

    localparam logic [c_st_w-1:0] c_st_idle  = 2'd0;
    localparam logic [c_st_w-1:0] c_st_issue = 2'd1;
    localparam logic [c_st_w-1:0] c_st_wait  = 2'd2;
    localparam logic [c_st_w-1:0] c_st_resp  = 2'd3;

    localparam logic [c_sel_w-1:0] c_op_and  = 2'd0;
    localparam logic [c_sel_w-1:0] c_op_or   = 2'd1;
    localparam logic [c_sel_w-1:0] c_op_xnor = 2'd2;
    localparam logic [c_sel_w-1:0] c_op_xor  = 2'd3;

    // Reference behaviour of the external datapath this arbiter feeds.
    function automatic logic [c_data_w-1:0] op_eval(
        input logic [c_data_w-1:0] a,
        input logic [c_data_w-1:0] b,
        input logic [c_sel_w-1:0]  sel
    );
        case (sel)
            c_op_and:  op_eval = a & b;
            c_op_or:   op_eval = a | b;
            c_op_xnor: op_eval = ~(a ^ b);
            default:   op_eval = a ^ b;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_op_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_rr_arb
// Brief    : Round-robin search: first set request at or above ptr, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module logic_op_rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic [IW-1:0] w_cand;
    logic          w_found;

    // Candidate index wraps naturally because NREQ is a power of two.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = ptr + IW'(k);
            if (!w_found && req[w_cand]) begin
                w_found          = 1'b1;
                grant[w_cand]    = 1'b1;
                grant_idx        = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_op_arb.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_arb
// Brief    : Arbitrates four requesters onto one logic-op datapath, one
//            transaction in flight, with response timeout and backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module logic_op_arb
    import logic_op_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [c_data_w*NREQ-1:0]   req_in1,
    input  logic [c_data_w*NREQ-1:0]   req_in2,
    input  logic [c_sel_w*NREQ-1:0]    req_sel,
    output logic                       dp_in_en,
    output logic [c_data_w-1:0]        dp_in1,
    output logic [c_data_w-1:0]        dp_in2,
    output logic [c_sel_w-1:0]         dp_sel,
    input  logic [c_data_w-1:0]        dp_out,
    input  logic                       dp_out_en,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [c_data_w-1:0]        rsp_data,
    output logic                       rsp_err
);

    localparam int c_iw = $clog2(NREQ);
    localparam int c_cw = $clog2(TIMEOUT + 1);
    localparam logic [c_cw-1:0] c_timeout = c_cw'(TIMEOUT);

    logic [c_st_w-1:0]   r_state;
    logic [c_iw-1:0]     r_ptr;
    logic [c_iw-1:0]     r_id;
    logic [c_cw-1:0]     r_cnt;
    logic                r_dp_in_en;
    logic [c_data_w-1:0] r_dp_in1;
    logic [c_data_w-1:0] r_dp_in2;
    logic [c_sel_w-1:0]  r_dp_sel;
    logic                r_rsp_valid;
    logic [c_data_w-1:0] r_rsp_data;
    logic                r_rsp_err;

    logic [NREQ-1:0]     w_gnt;
    logic [c_iw-1:0]     w_gnt_idx;
    logic                w_any;
    logic [c_data_w-1:0] w_in1;
    logic [c_data_w-1:0] w_in2;
    logic [c_sel_w-1:0]  w_sel;
    logic [c_cw-1:0]     w_cnt_inc;

    logic_op_rr_arb #(
        .NREQ (NREQ),
        .IW   (c_iw)
    ) u_rr_arb (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_gnt),
        .grant_idx (w_gnt_idx)
    );

    assign w_any     = |req_valid;
    assign w_in1     = req_in1[c_data_w*w_gnt_idx +: c_data_w];
    assign w_in2     = req_in2[c_data_w*w_gnt_idx +: c_data_w];
    assign w_sel     = req_sel[c_sel_w*w_gnt_idx +: c_sel_w];
    assign w_cnt_inc = r_cnt + 1'b1;

    // The accept strobe must answer in the same cycle the request is seen,
    // so it stays combinational; gating with rst_n keeps it low in reset.
    assign req_ready = (rst_n && (r_state == c_st_idle)) ? w_gnt : '0;

    assign dp_in_en  = r_dp_in_en;
    assign dp_in1    = r_dp_in1;
    assign dp_in2    = r_dp_in2;
    assign dp_sel    = r_dp_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_dp_in_en  <= 1'b0;
            r_dp_in1    <= '0;
            r_dp_in2    <= '0;
            r_dp_sel    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_ptr      <= w_gnt_idx + 1'b1;
                        r_id       <= w_gnt_idx;
                        r_dp_in_en <= 1'b1;
                        r_dp_in1   <= w_in1;
                        r_dp_in2   <= w_in2;
                        r_dp_sel   <= w_sel;
                        r_state    <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_dp_in_en <= 1'b0;
                    r_dp_in1   <= '0;
                    r_dp_in2   <= '0;
                    r_dp_sel   <= '0;
                    r_cnt      <= '0;
                    r_state    <= c_st_wait;
                end
                c_st_wait: begin
                    // A result on the final counted cycle still beats the timeout.
                    if (dp_out_en) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= dp_out;
                        r_rsp_err   <= 1'b0;
                        r_state     <= c_st_resp;
                    end else if (w_cnt_inc == c_timeout) begin
                        r_cnt       <= w_cnt_inc;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= c_st_resp;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_op_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_op_arb
// Brief    : Randomized and directed bench for logic_op_arb against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_op_arb;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_in1, req_in2;
    logic [7:0]  req_sel;
    logic        dp_in_en;
    logic [3:0]  dp_in1, dp_in2;
    logic [1:0]  dp_sel;
    logic [3:0]  dp_out;
    logic        dp_out_en;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic        rsp_err;

    logic_op_arb #(.NREQ(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_sel(req_sel),
        .dp_in_en(dp_in_en), .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_sel(dp_sel),
        .dp_out(dp_out), .dp_out_en(dp_out_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++)
            if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        case (s)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return ~(a ^ b);
            default: return a ^ b;
        endcase
    endfunction

    // Reference model: one transaction at a time, phase tells where it is.
    localparam int P_FREE = 0, P_ISSUE = 1, P_WAIT = 2, P_RESP = 3;
    int         m_phase = P_FREE;
    int         m_ptr = 0, m_id = 0, m_waited = 0;
    logic [3:0] m_a = '0, m_b = '0, m_data = '0;
    logic [1:0] m_op = '0;
    logic       m_err = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_phase = P_FREE; m_ptr = 0; m_id = 0; m_waited = 0;
        end else begin
            case (m_phase)
                P_FREE: if (req_valid != 0) begin
                    m_id    = pick(req_valid, m_ptr);
                    m_ptr   = (m_id + 1) % 4;
                    m_a     = req_in1[4*m_id +: 4];
                    m_b     = req_in2[4*m_id +: 4];
                    m_op    = req_sel[2*m_id +: 2];
                    m_phase = P_ISSUE;
                end
                P_ISSUE: begin m_waited = 0; m_phase = P_WAIT; end
                P_WAIT: begin
                    if (dp_out_en) begin
                        m_data = dp_out; m_err = 1'b0; m_phase = P_RESP;
                    end else if (m_waited + 1 == TO) begin
                        m_data = 4'h0; m_err = 1'b1; m_phase = P_RESP;
                    end else m_waited++;
                end
                default: if (rsp_ready) m_phase = P_FREE;
            endcase
        end
    end

    typedef struct { int cyc; int idx; logic [3:0] a; logic [3:0] b; logic [1:0] s; logic e; } ev_t;
    ev_t gq[$];
    ev_t iq[$];
    ev_t rq[$];
    int         iss_seq = 0;
    logic [3:0] iss_res = '0;

    // Per-cycle compare against the model, plus event logs for directed checks.
    always @(negedge clk) begin
        logic [3:0] e_ready;
        ev_t ev;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_dp_in_en", dp_in_en, 0);
            chk("rst_dp_ops", {dp_in1, dp_in2, dp_sel}, 0);
            chk("rst_rsp", {rsp_valid, rsp_id, rsp_data, rsp_err}, 0);
        end else begin
            e_ready = '0;
            if (m_phase == P_FREE && req_valid != 0) e_ready[pick(req_valid, m_ptr)] = 1'b1;
            chk("req_ready", req_ready, e_ready);
            chk("dp_in_en", dp_in_en, m_phase == P_ISSUE);
            chk("dp_in1", dp_in1, (m_phase == P_ISSUE) ? m_a : 4'h0);
            chk("dp_in2", dp_in2, (m_phase == P_ISSUE) ? m_b : 4'h0);
            chk("dp_sel", dp_sel, (m_phase == P_ISSUE) ? m_op : 2'h0);
            chk("rsp_valid", rsp_valid, m_phase == P_RESP);
            if (m_phase == P_RESP) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_err", rsp_err, m_err);
            end
            ev = '{cyc, 0, dp_in1, dp_in2, dp_sel, 1'b0};
            if (req_ready != 0) begin
                for (int k = 0; k < 4; k++) if (req_ready[k]) ev.idx = k;
                gq.push_back(ev);
            end
            if (dp_in_en) begin
                iq.push_back(ev);
                iss_res = op(dp_in1, dp_in2, dp_sel);
                iss_seq++;
            end
            if (rsp_valid && rsp_ready) rq.push_back('{cyc, int'(rsp_id), rsp_data, 4'h0, 2'h0, rsp_err});
        end
    end

    // Datapath stand-in: random latency, optional dead mode, spurious strobes.
    int         dp_lat_max = 1;
    logic       dp_dead = 1'b0, dp_spur = 1'b0, dp_inject = 1'b0;
    int         last_seq = 0, pend_cnt = 0;
    logic       pend = 1'b0;
    logic [3:0] pend_res = '0;

    initial begin dp_out_en = 1'b0; dp_out = '0; end
    always @(posedge clk) begin
        #2;
        dp_out_en = 1'b0;
        dp_out    = 4'($urandom);
        if (!rst_n) begin
            pend = 1'b0; last_seq = iss_seq;
        end else begin
            if (iss_seq != last_seq) begin
                last_seq = iss_seq;
                if (!dp_dead) begin
                    pend = 1'b1; pend_res = iss_res;
                    pend_cnt = $urandom_range(dp_lat_max, 1);
                end
            end
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin dp_out_en = 1'b1; dp_out = pend_res; pend = 1'b0; end
            end else if (dp_inject || (dp_spur && $urandom_range(9, 0) == 0)) begin
                dp_out_en = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_q(input string name, input int which, input int target, input int budget);
        int sz;
        for (int i = 0; i < budget; i++) begin
            sz = (which == 0) ? gq.size() : (which == 1) ? iq.size() : rq.size();
            if (sz >= target) break;
            tick(1);
        end
        sz = (which == 0) ? gq.size() : (which == 1) ? iq.size() : rq.size();
        chk(name, sz >= target, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int gb, rb, ib;
        logic [3:0]  exp_d [1:3];
        logic [6:0]  snap;
        rst_n = 1'b0; req_valid = 4'hF; req_in1 = '0; req_in2 = '0; req_sel = '0;
        rsp_ready = 1'b1;
        tick(3);
        chk("reset_ready_masked", req_ready, 0);
        req_valid = 4'h0;
        rst_n = 1'b1;
        tick(2);

        // Single request, AND
        gb = gq.size(); rb = rq.size(); ib = iq.size();
        req_valid = 4'b0001; req_in1 = 16'h000A; req_in2 = 16'h0006; req_sel = 8'h00;
        wait_q("t1_grant", 0, gb + 1, 10);
        req_valid = 4'h0;
        wait_q("t1_resp", 2, rb + 1, 20);
        chk("t1_grant_idx", gq[gb].idx, 0);
        chk("t1_issue_lat", iq[ib].cyc - gq[gb].cyc, 1);
        chk("t1_issue_ops", {iq[ib].a, iq[ib].b, iq[ib].s}, {4'hA, 4'h6, 2'd0});
        chk("t1_resp_lat", rq[rb].cyc - gq[gb].cyc, 3);
        chk("t1_resp", {rq[rb].idx[1:0], rq[rb].a, rq[rb].e}, {2'd0, 4'h2, 1'b0});

        // Op coverage on requester 2
        exp_d[1] = 4'hE; exp_d[2] = 4'h9; exp_d[3] = 4'h6;
        for (int s = 1; s <= 3; s++) begin
            gb = gq.size(); rb = rq.size();
            req_valid = 4'b0100; req_in1 = 16'h0C00; req_in2 = 16'h0A00;
            req_sel = 8'(s << 4);
            wait_q("op_grant", 0, gb + 1, 10);
            req_valid = 4'h0;
            wait_q("op_resp", 2, rb + 1, 20);
            chk($sformatf("op_sel%0d_data", s), rq[rb].a, exp_d[s]);
            chk($sformatf("op_sel%0d_id", s), rq[rb].idx, 2);
        end

        // Timeout, then normal completion
        dp_dead = 1'b1;
        gb = gq.size(); rb = rq.size();
        req_valid = 4'b0010;
        wait_q("to_grant", 0, gb + 1, 10);
        req_valid = 4'h0;
        wait_q("to_resp", 2, rb + 1, 40);
        chk("to_resp", {rq[rb].idx[1:0], rq[rb].a, rq[rb].e}, {2'd1, 4'h0, 1'b1});
        chk("to_lat", rq[rb].cyc - gq[gb].cyc, TO + 2);
        dp_dead = 1'b0;
        gb = gq.size(); rb = rq.size();
        req_valid = 4'b0010; req_in1 = 16'h0050; req_in2 = 16'h0030; req_sel = 8'h0C;
        wait_q("to2_grant", 0, gb + 1, 10);
        req_valid = 4'h0;
        wait_q("to2_resp", 2, rb + 1, 20);
        chk("to2_resp", {rq[rb].idx[1:0], rq[rb].a, rq[rb].e}, {2'd1, 4'h6, 1'b0});

        // Backpressure
        rb = rq.size();
        rsp_ready = 1'b0; req_valid = 4'b1001; req_in1 = 16'h7003; req_in2 = 16'hB005;
        req_sel = 8'b01_00_00_11;
        for (int i = 0; i < 20; i++) begin
            tick(1); @(negedge clk);
            if (rsp_valid) break;
        end
        chk("bp_valid", rsp_valid, 1);
        snap = {rsp_id, rsp_data, rsp_err};
        chk("bp_first", snap, {2'd3, 4'hF, 1'b0});
        for (int k = 0; k < 5; k++) begin
            tick(1); @(negedge clk);
            chk("bp_hold", {rsp_valid, rsp_id, rsp_data, rsp_err}, {1'b1, snap});
            chk("bp_no_grant", req_ready, 0);
        end
        tick(1); rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake", rsp_valid, 1);
        tick(1); @(negedge clk);
        chk("bp_next_grant", req_ready, 4'b0001);
        tick(1); req_valid = 4'h0;
        wait_q("bp_drain", 2, rb + 2, 30);

        // Reset during WAIT
        dp_dead = 1'b1;
        gb = gq.size(); ib = iq.size();
        req_valid = 4'b0100;
        wait_q("rw_grant", 0, gb + 1, 10);
        chk("rw_grant_idx", gq[gb].idx, 2);
        req_valid = 4'h0;
        wait_q("rw_issue", 1, ib + 1, 10);
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_async_dp", {dp_in_en, dp_in1, dp_in2, dp_sel}, 0);
        chk("rw_async_rsp", {rsp_valid, rsp_id, rsp_data, rsp_err}, 0);
        tick(2);
        rst_n = 1'b1; dp_dead = 1'b0; dp_inject = 1'b1;
        rb = rq.size();
        tick(1); dp_inject = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk("rw_no_resp", rsp_valid, 0);
            tick(1);
        end
        chk("rw_resp_count", rq.size(), rb);
        gb = gq.size(); rb = rq.size();
        req_valid = 4'hF;
        wait_q("rw_grant2", 0, gb + 1, 10);
        chk("rw_first_from0", gq[gb].idx, 0);
        req_valid = 4'h0;
        wait_q("rw_resp2", 2, rb + 1, 20);

        // Fairness after a fresh reset
        rst_n = 1'b0; tick(2); rst_n = 1'b1;
        gb = gq.size(); rb = rq.size();
        req_valid = 4'hF; req_in1 = 16'($urandom); req_in2 = 16'($urandom); req_sel = 8'($urandom);
        wait_q("fair_grants", 0, gb + 5, 40);
        req_valid = 4'h0;
        for (int k = 0; k < 5; k++) chk($sformatf("fair_idx%0d", k), gq[gb+k].idx, k % 4);
        for (int k = 1; k < 5; k++) chk($sformatf("fair_gap%0d", k), gq[gb+k].cyc - gq[gb+k-1].cyc, 4);
        wait_q("fair_drain", 2, rb + 5, 30);

        // Randomized traffic
        dp_lat_max = 4; dp_spur = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(1, 0) == 0) req_valid = 4'($urandom);
            req_in1   = 16'($urandom);
            req_in2   = 16'($urandom);
            req_sel   = 8'($urandom);
            rsp_ready = ($urandom_range(3, 0) != 0);
            dp_dead   = ($urandom_range(15, 0) == 0);
            if (i % 500 == 250) begin
                #2 rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            tick(1);
        end
        req_valid = 4'h0; rsp_ready = 1'b1; dp_dead = 1'b0; dp_spur = 1'b0;
        tick(40);
        chk("final_idle", {rsp_valid, dp_in_en}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_op_arb.md
LOGIC_OP_ARB -- requirements
Module: logic_op_arb

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (fixed at 4 in this revision).
REQ-002 Parameter: TIMEOUT, 15, maximum WAIT cycles before an error response.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  4  per-requester request valid.
REQ-006 req_ready  output  4  per-requester accept strobe, one-hot or zero.
REQ-007 req_in1  input  16  operand 1, 4 bits per requester; requester i uses bits [4i+3:4i].
REQ-008 req_in2  input  16  operand 2, packed the same way.
REQ-009 req_sel  input  8  operation select, 2 bits per requester: 0 AND, 1 OR, 2 XNOR, 3 XOR.
REQ-010 dp_in_en  output  1  datapath issue strobe.
REQ-011 dp_in1, dp_in2  output  4  datapath operands.
REQ-012 dp_sel  output  2  datapath operation select.
REQ-013 dp_out  input  4  datapath result.
REQ-014 dp_out_en  input  1  datapath result valid.
REQ-015 rsp_valid  output  1  response valid.
REQ-016 rsp_ready  input  1  response accept.
REQ-017 rsp_id  output  2  index of the requester that owns the response.
REQ-018 rsp_data  output  4  result.
REQ-019 rsp_err  output  1  timeout flag qualifying the response.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; exactly one transaction SHALL be in flight at a time.
REQ-021 IDLE: if any req_valid is set, grant the first set bit searching round-robin upward from rr_ptr with wrap 3->0; assert req_ready[grant] for that cycle only; capture operands, select and id; go to ISSUE.
REQ-022 On grant, rr_ptr SHALL become (grant+1) mod 4.
REQ-023 ISSUE: dp_in_en=1 for exactly one cycle with the captured operands and select; go to WAIT with the wait counter cleared.
REQ-024 dp_in1, dp_in2 and dp_sel SHALL be 0 whenever dp_in_en=0.
REQ-025 WAIT: when dp_out_en=1, capture dp_out into rsp_data with rsp_err=0 and go to RESP; otherwise increment the counter.
REQ-026 Timeout: when the counter reaches TIMEOUT with dp_out_en still 0, set rsp_data=0 and rsp_err=1 and go to RESP.
REQ-027 dp_out_en SHALL be ignored in IDLE, ISSUE and RESP.
REQ-028 RESP: hold rsp_valid, rsp_id, rsp_data and rsp_err stable until rsp_valid && rsp_ready; on that cycle go to IDLE.
REQ-029 Nominal timing with a 1-cycle datapath: grant at cycle N, dp_in_en at N+1, dp_out_en at N+2, rsp_valid from N+3.
REQ-030 Minimum grant-to-grant spacing SHALL be 4 cycles when rsp_ready is held high.
REQ-031 A requester deasserting req_valid before its grant SHALL be skipped with no side effect.

Reset
REQ-032 While rst_n=0, the following SHALL all be 0 and the FSM SHALL be in IDLE: all outputs, rr_ptr, the wait counter and the captured registers.
REQ-033 Reset mid-transaction SHALL abandon the transaction and produce no response.
REQ-034 The first grant after reset SHALL start the search from requester 0.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the op-select codes (AND/OR/XNOR/XOR) and the default TIMEOUT.
REQ-036 The round-robin search SHALL be one sub-module, logic_op_rr_arb (inputs req and ptr; outputs grant one-hot and grant index).

Verification
REQ-037 Single request: req_valid=4'b0001, in1=4'hA, in2=4'h6, sel=0 -> dp_in_en one cycle after grant with dp_in1=A, dp_in2=6, dp_sel=0; model returns 4'h2 -> rsp_id=0, rsp_data=4'h2, rsp_err=0.
REQ-038 Fairness: all four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0 and grants exactly 4 cycles apart.
REQ-039 Timeout: dp_out_en tied 0 -> after TIMEOUT WAIT cycles, rsp_valid=1, rsp_err=1, rsp_data=0; next request completes normally.
REQ-040 Backpressure: rsp_ready=0 for 5 cycles -> rsp fields stable, no new grant; rsp_ready=1 -> return to IDLE the next cycle.
REQ-041 Reset during WAIT: rst_n pulsed low -> all outputs 0 asynchronously; a late dp_out_en produces no response; next grant from requester 0.
REQ-042 Op coverage: in1=4'hC, in2=4'hA with sel 1/2/3 -> rsp_data=4'hE, 4'h9, 4'h6 respectively.
